register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 17 +
 rtl/register_file_rf_read_port.sv | 43 ++++
 rtl/register_file.sv | 105 ++++++++++
 tb/tb_register_file.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared constants and types for the rename-aware architectural register file.
package register_file_pkg;

    localparam int REG_COUNT             = 32;
    localparam int REG_ADDR_BIT          = 5;
    localparam int DATA_BIT              = 32;
    localparam int ROB_INDEX_BIT_DEFAULT = 4;

    typedef logic [REG_ADDR_BIT-1:0] reg_addr_t;
    typedef logic [DATA_BIT-1:0]     data_t;

    // x0 is hardwired: it is never written, never renamed, and always reads 0.
    function automatic logic is_writable(input reg_addr_t rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/register_file_rf_read_port.sv
// One combinational operand lookup: value/busy/tag of a source register, with
// a bypass of the value being committed this cycle by the producing ROB slot.
module rf_read_port
    import register_file_pkg::*;
#(
    parameter int ROB_INDEX_BIT = ROB_INDEX_BIT_DEFAULT
) (
    input  logic [REG_ADDR_BIT-1:0]  addr,
    input  logic [DATA_BIT-1:0]      values [REG_COUNT],
    input  logic [REG_COUNT-1:0]     busy,
    input  logic [ROB_INDEX_BIT-1:0] tags [REG_COUNT],
    input  logic [REG_ADDR_BIT-1:0]  commit_rd,
    input  logic [DATA_BIT-1:0]      commit_val,
    input  logic [ROB_INDEX_BIT-1:0] commit_rob_id,
    output logic [DATA_BIT-1:0]      val,
    output logic                     pending,
    output logic [ROB_INDEX_BIT-1:0] tag
);

    logic bypass;

    // The operand is resolved this very cycle if its producer is the slot committing now.
    assign bypass = busy[addr] && (commit_rd == addr) && (tags[addr] == commit_rob_id);

    // Select the stored value, the in-flight commit value, or the pending tag.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        val     = '0;
        pending = 1'b0;
        tag     = '0;
        if (!is_writable(addr)) begin
            val     = '0;
        end else if (bypass) begin
            val     = commit_val;
        end else begin
            val     = values[addr];
            pending = busy[addr];
            tag     = busy[addr] ? tags[addr] : '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename state: each register holds a value,
// a busy bit and the ROB slot that will produce its next value.
module register_file
    import register_file_pkg::*;
#(
    parameter int ROB_INDEX_BIT = ROB_INDEX_BIT_DEFAULT
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic                     issue_req,
    input  logic [REG_ADDR_BIT-1:0]  issue_rd,
    input  logic [ROB_INDEX_BIT-1:0] issue_rob_id,
    input  logic [REG_ADDR_BIT-1:0]  commit_rd,
    input  logic [DATA_BIT-1:0]      commit_val,
    input  logic [ROB_INDEX_BIT-1:0] commit_rob_id,
    input  logic [REG_ADDR_BIT-1:0]  rs1_addr,
    input  logic [REG_ADDR_BIT-1:0]  rs2_addr,
    output logic [DATA_BIT-1:0]      rs1_val,
    output logic [DATA_BIT-1:0]      rs2_val,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [ROB_INDEX_BIT-1:0] rs1_tag,
    output logic [ROB_INDEX_BIT-1:0] rs2_tag
);

    data_t                    values [REG_COUNT];
    logic [REG_COUNT-1:0]     busy;
    logic [ROB_INDEX_BIT-1:0] tags [REG_COUNT];

    logic issue_fire;
    logic commit_fire;
    logic commit_retires;

    // A flush suppresses renaming; x0 is never renamed or written.
    assign issue_fire  = issue_req && is_writable(issue_rd) && !clear_in;
    assign commit_fire = is_writable(commit_rd);

    // Busy drops only if the committing slot is still the newest producer and
    // no younger instruction renames the same register in this cycle.
    assign commit_retires = commit_fire
                         && (tags[commit_rd] == commit_rob_id)
                         && !(issue_fire && (issue_rd == commit_rd));

    // Rename and commit state update; everything holds while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            // NOTE: the value array is reset on purpose because registers must read
            // as zero after reset; this rules out mapping it onto a reset-less RAM.
            for (int i = 0; i < REG_COUNT; i++) begin
                values[i] <= '0;
                tags[i]   <= '0;
            end
            busy <= '0;
        end else if (rdy_in) begin
            // NOTE: non-blocking assignments, so every read above sees pre-edge state
            // regardless of statement order.
            if (commit_fire) begin
                values[commit_rd] <= commit_val;
            end
            if (clear_in) begin
                busy <= '0;
                for (int i = 0; i < REG_COUNT; i++) begin
                    tags[i] <= '0;
                end
            end else begin
                if (commit_retires) begin
                    busy[commit_rd] <= 1'b0;
                end
                if (issue_fire) begin
                    busy[issue_rd] <= 1'b1;
                    tags[issue_rd] <= issue_rob_id;
                end
            end
        end
    end

    rf_read_port #(.ROB_INDEX_BIT(ROB_INDEX_BIT)) u_rs1_port (
        .addr          (rs1_addr),
        .values        (values),
        .busy          (busy),
        .tags          (tags),
        .commit_rd     (commit_rd),
        .commit_val    (commit_val),
        .commit_rob_id (commit_rob_id),
        .val           (rs1_val),
        .pending       (rs1_busy),
        .tag           (rs1_tag)
    );

    rf_read_port #(.ROB_INDEX_BIT(ROB_INDEX_BIT)) u_rs2_port (
        .addr          (rs2_addr),
        .values        (values),
        .busy          (busy),
        .tags          (tags),
        .commit_rd     (commit_rd),
        .commit_val    (commit_val),
        .commit_rob_id (commit_rob_id),
        .val           (rs2_val),
        .pending       (rs2_busy),
        .tag           (rs2_tag)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, hand-written
// flush and reset sequences, then randomized traffic against a reference model.
module tb_register_file;
    import register_file_pkg::*;

    localparam int RIB = ROB_INDEX_BIT_DEFAULT;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            rdy_in;
    logic            clear_in;
    logic            issue_req;
    logic [4:0]      issue_rd;
    logic [RIB-1:0]  issue_rob_id;
    logic [4:0]      commit_rd;
    logic [31:0]     commit_val;
    logic [RIB-1:0]  commit_rob_id;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [31:0]     rs1_val;
    logic [31:0]     rs2_val;
    logic            rs1_busy;
    logic            rs2_busy;
    logic [RIB-1:0]  rs1_tag;
    logic [RIB-1:0]  rs2_tag;

    int n_checks = 0;
    int n_errors = 0;

    register_file #(.ROB_INDEX_BIT(RIB)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .clear_in      (clear_in),
        .issue_req     (issue_req),
        .issue_rd      (issue_rd),
        .issue_rob_id  (issue_rob_id),
        .commit_rd     (commit_rd),
        .commit_val    (commit_val),
        .commit_rob_id (commit_rob_id),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rs1_tag       (rs1_tag),
        .rs2_tag       (rs2_tag)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    logic [31:0]    m_val  [32];
    logic           m_busy [32];
    logic [RIB-1:0] m_tag  [32];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    // Expected {val, busy, tag} of a read under the current driven inputs.
    function automatic logic [63:0] model_read(input logic [4:0] a);
        if (a == 0)
            return 64'd0;
        if (m_busy[a] && commit_rd == a && m_tag[a] == commit_rob_id)
            return {27'd0, commit_val, 1'b0, {RIB{1'b0}}};
        return {27'd0, m_val[a], m_busy[a], m_busy[a] ? m_tag[a] : {RIB{1'b0}}};
    endfunction

    // Apply one clock edge's worth of the architectural rules to the model.
    task automatic model_step();
        logic renaming;
        if (!rdy_in) return;
        renaming = issue_req && issue_rd != 0 && !clear_in;
        if (commit_rd != 0) begin
            m_val[commit_rd] = commit_val;
            if (m_tag[commit_rd] == commit_rob_id && !(renaming && issue_rd == commit_rd))
                m_busy[commit_rd] = 1'b0;
        end
        if (clear_in) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] = 1'b0;
                m_tag[i]  = '0;
            end
        end else if (renaming) begin
            m_busy[issue_rd] = 1'b1;
            m_tag[issue_rd]  = issue_rob_id;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] pack(input logic [31:0] v, input logic b, input logic [RIB-1:0] t);
        return {27'd0, v, b, t};
    endfunction

    task automatic drive(input logic rdy, input logic clr, input logic ireq, input logic [4:0] ird,
                         input logic [RIB-1:0] iid, input logic [4:0] crd, input logic [31:0] cval,
                         input logic [RIB-1:0] cid, input logic [4:0] a1, input logic [4:0] a2);
        rdy_in        = rdy;
        clear_in      = clr;
        issue_req     = ireq;
        issue_rd      = ird;
        issue_rob_id  = iid;
        commit_rd     = crd;
        commit_val    = cval;
        commit_rob_id = cid;
        rs1_addr      = a1;
        rs2_addr      = a2;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        drive(1'b1, 1'b0, 1'b0, 5'd0, '0, 5'd0, 32'd0, '0, a1, a2);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic           rdy, clr, ireq;
        logic [4:0]     ird;
        logic [RIB-1:0] iid;
        logic [4:0]     crd;
        logic [31:0]    cval;
        logic [RIB-1:0] cid;
        logic [4:0]     a1, a2;
        logic [63:0]    e1, e2;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic clr, input logic ireq, input logic [4:0] ird,
                                input logic [RIB-1:0] iid, input logic [4:0] crd, input logic [31:0] cval,
                                input logic [RIB-1:0] cid, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [63:0] e1, input logic [63:0] e2);
        vec_t v;
        v.rdy = rdy; v.clr = clr; v.ireq = ireq; v.ird = ird; v.iid = iid;
        v.crd = crd; v.cval = cval; v.cid = cid; v.a1 = a1; v.a2 = a2;
        v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    vec_t table_v [15];

    initial begin
        // Expected outputs are the combinational reads before the vector's edge.
        table_v[0]  = mk(1,0,0,0,0, 0,0,0,        5,0, pack(0,0,0),        pack(0,0,0));
        table_v[1]  = mk(1,0,1,5,3, 0,0,0,        5,0, pack(0,0,0),        pack(0,0,0));
        table_v[2]  = mk(1,0,0,0,0, 0,0,0,        5,0, pack(0,1,3),        pack(0,0,0));
        table_v[3]  = mk(1,0,0,0,0, 5,32'h1234,3, 5,5, pack(32'h1234,0,0), pack(32'h1234,0,0));
        table_v[4]  = mk(1,0,0,0,0, 0,0,0,        5,0, pack(32'h1234,0,0), pack(0,0,0));
        table_v[5]  = mk(1,0,1,7,2, 0,0,0,        7,5, pack(0,0,0),        pack(32'h1234,0,0));
        table_v[6]  = mk(1,0,1,7,6, 0,0,0,        7,0, pack(0,1,2),        pack(0,0,0));
        table_v[7]  = mk(1,0,0,0,0, 7,9,2,        7,0, pack(0,1,6),        pack(0,0,0));
        table_v[8]  = mk(1,0,0,0,0, 0,0,0,        7,5, pack(9,1,6),        pack(32'h1234,0,0));
        table_v[9]  = mk(1,0,1,4,5, 4,32'hAA,1,   4,0, pack(0,0,0),        pack(0,0,0));
        table_v[10] = mk(1,0,0,0,0, 0,0,0,        4,7, pack(32'hAA,1,5),   pack(9,1,6));
        table_v[11] = mk(1,0,1,0,3, 0,32'hFFFF,0, 0,0, pack(0,0,0),        pack(0,0,0));
        table_v[12] = mk(1,0,0,0,0, 0,0,0,        0,0, pack(0,0,0),        pack(0,0,0));
        table_v[13] = mk(0,0,1,6,4, 5,32'h55,0,   6,5, pack(0,0,0),        pack(32'h1234,0,0));
        table_v[14] = mk(1,0,0,0,0, 0,0,0,        6,5, pack(0,0,0),        pack(32'h1234,0,0));
    end

    // ---------------- test sequence ----------------
    initial begin
        rst_in = 1'b1;
        idle(5'd5, 5'd0);
        model_reset();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        #1;
        check("reset.x5", pack(rs1_val, rs1_busy, rs1_tag), pack(0,0,0));
        check("reset.x0", pack(rs2_val, rs2_busy, rs2_tag), pack(0,0,0));
        rst_in = 1'b0;

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_in);
            drive(table_v[i].rdy, table_v[i].clr, table_v[i].ireq, table_v[i].ird, table_v[i].iid,
                  table_v[i].crd, table_v[i].cval, table_v[i].cid, table_v[i].a1, table_v[i].a2);
            #1;
            check($sformatf("vec%0d.rs1", i), pack(rs1_val, rs1_busy, rs1_tag), table_v[i].e1);
            check($sformatf("vec%0d.rs2", i), pack(rs2_val, rs2_busy, rs2_tag), table_v[i].e2);
            @(posedge clk_in);
        end

        // Flush: x8 gets a value, x3/x8/x9 renamed, then clear with a commit to x3.
        @(negedge clk_in); drive(1,0,0,0,0, 8,32'h88,0, 0,0); @(posedge clk_in);
        @(negedge clk_in); drive(1,0,1,3,1, 0,0,0,      0,0); @(posedge clk_in);
        @(negedge clk_in); drive(1,0,1,8,2, 0,0,0,      0,0); @(posedge clk_in);
        @(negedge clk_in); drive(1,0,1,9,3, 0,0,0,      0,0); @(posedge clk_in);
        @(negedge clk_in); drive(1,1,1,10,4, 3,32'd7,15, 8,9);
        #1;
        check("flush.pre.x8", pack(rs1_val, rs1_busy, rs1_tag), pack(32'h88,1,2));
        check("flush.pre.x9", pack(rs2_val, rs2_busy, rs2_tag), pack(0,1,3));
        @(posedge clk_in);
        @(negedge clk_in); idle(5'd3, 5'd8);
        #1;
        check("flush.x3", pack(rs1_val, rs1_busy, rs1_tag), pack(7,0,0));
        check("flush.x8", pack(rs2_val, rs2_busy, rs2_tag), pack(32'h88,0,0));
        @(negedge clk_in); idle(5'd9, 5'd10);
        #1;
        check("flush.x9",  pack(rs1_val, rs1_busy, rs1_tag), pack(0,0,0));
        check("flush.x10", pack(rs2_val, rs2_busy, rs2_tag), pack(0,0,0));

        // Asynchronous reset in the middle of operation.
        @(negedge clk_in); drive(1,0,0,0,0, 12,32'h77,0, 0,0); @(posedge clk_in);
        @(negedge clk_in); drive(1,0,1,12,5, 0,0,0, 12,0);     @(posedge clk_in);
        @(negedge clk_in); idle(5'd12, 5'd3);
        #1;
        check("prereset.x12", pack(rs1_val, rs1_busy, rs1_tag), pack(32'h77,1,5));
        #1 rst_in = 1'b1;
        #1;
        check("asyncreset.x12", pack(rs1_val, rs1_busy, rs1_tag), pack(0,0,0));
        check("asyncreset.x3",  pack(rs2_val, rs2_busy, rs2_tag), pack(0,0,0));
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        drive(1,0,1,13,7, 0,0,0, 13,12);
        @(posedge clk_in);
        model_step();
        @(negedge clk_in); idle(5'd13, 5'd12);
        #1;
        check("postreset.x13", pack(rs1_val, rs1_busy, rs1_tag), pack(0,1,7));
        check("postreset.x12", pack(rs2_val, rs2_busy, rs2_tag), pack(0,0,0));

        // Randomized traffic against the model; narrow register range forces collisions.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] crd;
            @(negedge clk_in);
            crd = 5'($urandom_range(0, 7));
            drive(($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)),
                  RIB'($urandom),
                  crd,
                  $urandom,
                  ($urandom_range(0, 2) != 0) ? m_tag[crd] : RIB'($urandom),
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
            #1;
            check($sformatf("rand%0d.rs1", n), pack(rs1_val, rs1_busy, rs1_tag), model_read(rs1_addr));
            check($sformatf("rand%0d.rs2", n), pack(rs2_val, rs2_busy, rs2_tag), model_read(rs2_addr));
            @(posedge clk_in);
            model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
